ex_mem_wb_dest_fwd: RTL and testbench
=====================================

// Module: ex_mem_wb_dest_fwd
// PURPOSE
//  Consumes the selected EX destination (rd / rt / $31 for JAL) and control bits.
//  Pipelines dest, write-enable and result through the EX/MEM and MEM/WB registers.
//  Produces the write-back port for the register file.
//  Produces forwarding selects and data for both EX-stage operands.
//  Flags the load-in-MEM hazard that forwarding cannot resolve.
// PARAMETERS
//  REG_AW  5   register address width
//  DATA_W  32  datapath width
// PORTS
//  clk            in   1       rising-edge clock
//  reset_n        in   1       asynchronous, active-low reset
//  stall          in   1       hold both pipeline registers
//  flush          in   1       insert bubble into EX/MEM
//  ex_reg_dest    in   REG_AW  selected destination from EX dest mux
//  ex_reg_write   in   1       EX instruction writes a register
//  ex_mem_to_reg  in   1       EX instruction is a load
//  ex_alu_result  in   DATA_W  ALU output
//  ex_rs, ex_rt   in   REG_AW  source addresses of the instruction now in EX
//  mem_read_data  in   DATA_W  data-memory read data for the MEM-stage instruction
//  mem_reg_dest   out  REG_AW  EX/MEM destination
//  mem_reg_write  out  1       EX/MEM write-enable
//  mem_alu_result out  DATA_W  EX/MEM result, also the data-memory address
//  wb_reg_dest    out  REG_AW  register-file write address
//  wb_reg_write   out  1       register-file write-enable
//  wb_write_data  out  DATA_W  register-file write data
//  fwd_a_sel      out  2       00 none, 01 from WB, 10 from MEM
//  fwd_b_sel      out  2       00 none, 01 from WB, 10 from MEM
//  fwd_a_data     out  DATA_W  forwarded value for rs (0 when sel = 00)
//  fwd_b_data     out  DATA_W  forwarded value for rt (0 when sel = 00)
//  fwd_hazard     out  1       load in MEM matches rs or rt
// BEHAVIOUR
//  Reset (async, reset_n = 0)
//   - All registered outputs are 0; both stages hold a bubble.
//   - The combinational outputs therefore read 0.
//  Each rising clk with reset_n = 1, the case applying takes effect:
//   - stall = 0, flush = 0
//     * EX/MEM <= {ex_reg_dest, ex_reg_write, ex_mem_to_reg, ex_alu_result}.
//     * MEM/WB <= {mem_reg_dest, mem_reg_write, wdata}.
//     * wdata = mem_read_data if the MEM-stage load bit is set, else mem_alu_result.
//   - flush = 1, stall = 0: EX/MEM <= bubble (all 0); MEM/WB advances normally.
//   - stall = 1, flush = 0: both registers hold their values.
//   - stall = 1, flush = 1: EX/MEM <= bubble; MEM/WB holds. No flush request is lost.
//  Writes to $0 are suppressed: wb_reg_write is forced to 0 when wb_reg_dest = 0.
//  Latency
//   - EX inputs appear on mem_* 1 cycle later and on wb_* 2 cycles later.
//   - No cycle is lost in a run without stalls.
//  Forwarding (combinational from registered state, per operand X = rs / rt):
//   - MEM match: mem_reg_write && mem_reg_dest != 0 && mem_reg_dest == X.
//   - WB match: wb_reg_write && wb_reg_dest == X.
//   - Not a load, MEM match -> sel 10, data = mem_alu_result.
//   - Load, MEM match -> sel 00 and fwd_hazard = 1.
//     * WB is not used as a fallback, because that value is stale.
//   - WB match only -> sel 01, data = wb_write_data.
//   - No match -> sel 00.
//   - MEM has priority over WB (youngest producer wins).
//  fwd_hazard is purely informational; the hazard unit must stall.
//  Reset asserted mid-operation discards in-flight instructions; nothing is retired.
// STRUCTURE
//  Package pipe_pkg holds:
//   - constants FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
//   - REG_ZERO = 5'd0;
//   - the EX/MEM and MEM/WB field layouts.
//  Sub-module fwd_operand_sel: one source address -> {sel, data, hazard}.
//   - Instantiated twice, for rs and rt.
//   - fwd_hazard = hazard_a | hazard_b.
// TESTING
//  1. Reset: pulse reset_n low mid-stream -> all outputs 0 immediately, asynchronously.
//  2. Forward from MEM: ALU write $5 = 0x1234, next instruction reads rs = 5
//     -> fwd_a_sel = 10, fwd_a_data = 0x1234.
//  3. Forward from WB: same $5, next instruction reads rt = 5 two instructions later
//     -> fwd_b_sel = 01, fwd_b_data = 0x1234.
//  4. Priority: $7 = 0xA (older) then $7 = 0xB (younger), with rs = 7
//     -> sel = 10, data = 0xB.
//  5. Load-in-MEM: load to $9 with mem_read_data = 0xDEAD, next instruction reads rs = 9
//     -> fwd_hazard = 1, sel = 00.
//     One cycle later wb_write_data = 0xDEAD, and the following instruction sees sel = 01.
//  6. Control corner cases:
//     - $0 write -> wb_reg_write = 0.
//     - stall + flush -> mem_* = 0 and wb_* unchanged.
//     - JAL dest 31 -> wb_reg_dest = 31 after 2 cycles.

Source files
------------

// File: rtl/ex_mem_wb_dest_fwd_pkg.sv
// Shared constants and pipeline-register field layouts for the EX/MEM/WB
// destination pipeline and its operand forwarding.
package pipe_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] result;
    } ex_mem_t;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic [DATA_W-1:0] wdata;
    } mem_wb_t;

endpackage

// File: rtl/ex_mem_wb_dest_fwd_if.sv
// Bundle of EX-stage inputs and MEM/WB/forwarding outputs; the pipeline
// block is the slave, the driving core (or bench) is the master.
interface ex_mem_wb_dest_fwd_if;
    import pipe_pkg::*;

    logic              stall;
    logic              flush;
    logic [REG_AW-1:0] ex_reg_dest;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic [DATA_W-1:0] ex_alu_result;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [DATA_W-1:0] mem_read_data;

    logic [REG_AW-1:0] mem_reg_dest;
    logic              mem_reg_write;
    logic [DATA_W-1:0] mem_alu_result;
    logic [REG_AW-1:0] wb_reg_dest;
    logic              wb_reg_write;
    logic [DATA_W-1:0] wb_write_data;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [DATA_W-1:0] fwd_a_data;
    logic [DATA_W-1:0] fwd_b_data;
    logic              fwd_hazard;

    modport master (
        output stall, flush, ex_reg_dest, ex_reg_write, ex_mem_to_reg,
               ex_alu_result, ex_rs, ex_rt, mem_read_data,
        input  mem_reg_dest, mem_reg_write, mem_alu_result, wb_reg_dest,
               wb_reg_write, wb_write_data, fwd_a_sel, fwd_b_sel,
               fwd_a_data, fwd_b_data, fwd_hazard
    );

    modport slave (
        input  stall, flush, ex_reg_dest, ex_reg_write, ex_mem_to_reg,
               ex_alu_result, ex_rs, ex_rt, mem_read_data,
        output mem_reg_dest, mem_reg_write, mem_alu_result, wb_reg_dest,
               wb_reg_write, wb_write_data, fwd_a_sel, fwd_b_sel,
               fwd_a_data, fwd_b_data, fwd_hazard
    );

endinterface

// File: rtl/ex_mem_wb_dest_fwd_fwd_sel.sv
// Forwarding decision for one EX source operand: youngest producer wins,
// and a load still in MEM raises a hazard instead of forwarding.
module fwd_operand_sel
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_write,
    input  logic              mem_load,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_write,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] data,
    output logic              hazard
);

    logic mem_match;
    logic wb_match;

    assign mem_match = mem_write && (mem_dest != REG_ZERO) && (mem_dest == src);
    assign wb_match  = wb_write && (wb_dest == src);

    always_comb begin
        sel    = FWD_NONE;
        data   = '0;
        hazard = 1'b0;
        if (mem_match) begin
            // The WB copy is older than the pending load, so it must not be used.
            if (mem_load) begin
                hazard = 1'b1;
            end else begin
                sel  = FWD_MEM;
                data = mem_data;
            end
        end else if (wb_match) begin
            sel  = FWD_WB;
            data = wb_data;
        end
    end

endmodule

// File: rtl/ex_mem_wb_dest_fwd.sv
// EX/MEM and MEM/WB pipeline registers for destination, write-enable and
// result, plus forwarding selects/data for both EX operands.
module ex_mem_wb_dest_fwd
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    ex_mem_wb_dest_fwd_if.slave   bus
);

    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [DATA_W-1:0] wdata;
    logic              wb_write_en;

    always_comb begin
        wdata    = ex_mem_q.mem_to_reg ? bus.mem_read_data : ex_mem_q.result;
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        // Flush wins over stall so a bubble request is never dropped.
        if (bus.flush) begin
            ex_mem_d = '0;
        end else if (!bus.stall) begin
            ex_mem_d = '{dest:       bus.ex_reg_dest,
                         reg_write:  bus.ex_reg_write,
                         mem_to_reg: bus.ex_mem_to_reg,
                         result:     bus.ex_alu_result};
        end
        if (!bus.stall) begin
            mem_wb_d = '{dest:      ex_mem_q.dest,
                         reg_write: ex_mem_q.reg_write,
                         wdata:     wdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign wb_write_en        = mem_wb_q.reg_write && (mem_wb_q.dest != REG_ZERO);

    assign bus.mem_reg_dest   = ex_mem_q.dest;
    assign bus.mem_reg_write  = ex_mem_q.reg_write;
    assign bus.mem_alu_result = ex_mem_q.result;
    assign bus.wb_reg_dest    = mem_wb_q.dest;
    assign bus.wb_reg_write   = wb_write_en;
    assign bus.wb_write_data  = mem_wb_q.wdata;

    logic [REG_AW-1:0] op_src [2];
    logic [1:0]        op_sel [2];
    logic [DATA_W-1:0] op_data[2];
    logic [1:0]        op_haz;

    assign op_src[0] = bus.ex_rs;
    assign op_src[1] = bus.ex_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            fwd_operand_sel u_sel (
                .src       (op_src[gi]),
                .mem_dest  (ex_mem_q.dest),
                .mem_write (ex_mem_q.reg_write),
                .mem_load  (ex_mem_q.mem_to_reg),
                .mem_data  (ex_mem_q.result),
                .wb_dest   (mem_wb_q.dest),
                .wb_write  (wb_write_en),
                .wb_data   (mem_wb_q.wdata),
                .sel       (op_sel[gi]),
                .data      (op_data[gi]),
                .hazard    (op_haz[gi])
            );
        end
    endgenerate

    assign bus.fwd_a_sel  = op_sel[0];
    assign bus.fwd_b_sel  = op_sel[1];
    assign bus.fwd_a_data = op_data[0];
    assign bus.fwd_b_data = op_data[1];
    assign bus.fwd_hazard = |op_haz;

endmodule

// File: tb/tb_ex_mem_wb_dest_fwd.sv
// Directed and randomized checks of the EX/MEM/WB pipeline and forwarding
// against an instruction-level model of what sits in MEM and WB.
module tb_ex_mem_wb_dest_fwd;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    ex_mem_wb_dest_fwd_if bus();

    ex_mem_wb_dest_fwd dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-flight instruction record; index 0 = MEM (youngest), 1 = WB.
    typedef struct {
        logic [4:0]  dest;
        logic        we;
        logic        load;
        logic [31:0] val;
    } rec_t;

    rec_t pipe_m[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic rec_t empty_rec();
        rec_t r;
        r.dest = '0; r.we = 1'b0; r.load = 1'b0; r.val = '0;
        return r;
    endfunction

    // Search in-flight producers youngest first; a pending load blocks forwarding.
    task automatic model_fwd(input logic [4:0] src, output logic [1:0] sel,
                             output logic [31:0] d, output logic h);
        sel = 2'b00; d = '0; h = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (pipe_m[i].we && pipe_m[i].dest != 0 && pipe_m[i].dest == src) begin
                if (i == 0 && pipe_m[i].load) h = 1'b1;
                else begin
                    sel = (i == 0) ? 2'b10 : 2'b01;
                    d   = pipe_m[i].val;
                end
                break;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0]  sa, sb;
        logic [31:0] da, db;
        logic        ha, hb;
        model_fwd(bus.ex_rs, sa, da, ha);
        model_fwd(bus.ex_rt, sb, db, hb);
        chk({tag, ".mem_dest"},  bus.mem_reg_dest,   pipe_m[0].dest);
        chk({tag, ".mem_we"},    bus.mem_reg_write,  pipe_m[0].we);
        chk({tag, ".mem_alu"},   bus.mem_alu_result, pipe_m[0].val);
        chk({tag, ".wb_dest"},   bus.wb_reg_dest,    pipe_m[1].dest);
        chk({tag, ".wb_we"},     bus.wb_reg_write,   pipe_m[1].we && pipe_m[1].dest != 0);
        chk({tag, ".wb_data"},   bus.wb_write_data,  pipe_m[1].val);
        chk({tag, ".fa_sel"},    bus.fwd_a_sel,      sa);
        chk({tag, ".fb_sel"},    bus.fwd_b_sel,      sb);
        chk({tag, ".fa_data"},   bus.fwd_a_data,     da);
        chk({tag, ".fb_data"},   bus.fwd_b_data,     db);
        chk({tag, ".hazard"},    bus.fwd_hazard,     ha | hb);
    endtask

    task automatic drive(input logic [4:0] d, input logic we, input logic ld,
                         input logic [31:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] rdata, input logic st, input logic fl);
        bus.ex_reg_dest   = d;
        bus.ex_reg_write  = we;
        bus.ex_mem_to_reg = ld;
        bus.ex_alu_result = alu;
        bus.ex_rs         = rs;
        bus.ex_rt         = rt;
        bus.mem_read_data = rdata;
        bus.stall         = st;
        bus.flush         = fl;
        #1;
    endtask

    // Advance one clock: the MEM instruction retires into WB with its final
    // value, the EX instruction enters MEM, subject to stall/flush.
    task automatic tick();
        rec_t nm, nw;
        nm = pipe_m[0];
        nw = pipe_m[1];
        if (!bus.stall) begin
            nw      = pipe_m[0];
            nw.load = 1'b0;
            nw.val  = pipe_m[0].load ? bus.mem_read_data : pipe_m[0].val;
        end
        if (bus.flush) nm = empty_rec();
        else if (!bus.stall) begin
            nm.dest = bus.ex_reg_dest;   nm.we  = bus.ex_reg_write;
            nm.load = bus.ex_mem_to_reg; nm.val = bus.ex_alu_result;
        end
        @(posedge clk);
        pipe_m[0] = nm;
        pipe_m[1] = nw;
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic [4:0] d, input logic we, input logic ld,
                       input logic [31:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rdata, input logic st, input logic fl);
        drive(d, we, ld, alu, rs, rt, rdata, st, fl);
        check_all(tag);
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".mem_dest"}, bus.mem_reg_dest,   '0);
        chk({tag, ".mem_we"},   bus.mem_reg_write,  '0);
        chk({tag, ".mem_alu"},  bus.mem_alu_result, '0);
        chk({tag, ".wb_dest"},  bus.wb_reg_dest,    '0);
        chk({tag, ".wb_we"},    bus.wb_reg_write,   '0);
        chk({tag, ".wb_data"},  bus.wb_write_data,  '0);
        chk({tag, ".fa_sel"},   bus.fwd_a_sel,      '0);
        chk({tag, ".fb_sel"},   bus.fwd_b_sel,      '0);
        chk({tag, ".fa_data"},  bus.fwd_a_data,     '0);
        chk({tag, ".fb_data"},  bus.fwd_b_data,     '0);
        chk({tag, ".hazard"},   bus.fwd_hazard,     '0);
    endtask

    initial begin
        logic [4:0]  saved_dest;
        logic        saved_we;
        logic [31:0] saved_data;
        checks = 0;
        errors = 0;
        pipe_m[0] = empty_rec();
        pipe_m[1] = empty_rec();

        // Power-on reset
        reset_n = 1'b0;
        drive(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        #2;
        check_zero("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Forward from MEM, then from WB
        cyc("t2a", 5'd5, 1'b1, 1'b0, 32'h1234, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 32'h0, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all("t2b");
        chk("t2.fa_sel",  bus.fwd_a_sel,  2'b10);
        chk("t2.fa_data", bus.fwd_a_data, 32'h1234);
        tick();
        drive(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd5, 32'h0, 1'b0, 1'b0);
        check_all("t3");
        chk("t3.fb_sel",  bus.fwd_b_sel,  2'b01);
        chk("t3.fb_data", bus.fwd_b_data, 32'h1234);
        tick();

        // Priority: younger producer in MEM beats older in WB
        cyc("t4a", 5'd7, 1'b1, 1'b0, 32'hA, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        cyc("t4b", 5'd7, 1'b1, 1'b0, 32'hB, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 32'h0, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all("t4c");
        chk("t4.fa_sel",  bus.fwd_a_sel,  2'b10);
        chk("t4.fa_data", bus.fwd_a_data, 32'hB);
        tick();

        // Load in MEM: hazard, no forwarding; next cycle the loaded value is in WB
        cyc("t5a", 5'd9, 1'b1, 1'b1, 32'h100, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 32'h0, 5'd9, 5'd0, 32'hDEAD, 1'b0, 1'b0);
        check_all("t5b");
        chk("t5.hazard", bus.fwd_hazard, 1'b1);
        chk("t5.fa_sel", bus.fwd_a_sel,  2'b00);
        tick();
        drive(5'd0, 1'b0, 1'b0, 32'h0, 5'd9, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all("t5c");
        chk("t5.wb_data", bus.wb_write_data, 32'hDEAD);
        chk("t5.fa_sel2", bus.fwd_a_sel,     2'b01);
        chk("t5.hazard2", bus.fwd_hazard,    1'b0);
        tick();

        // $0 write is suppressed at write-back and never forwarded
        cyc("t6a", 5'd0, 1'b1, 1'b0, 32'h55, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        cyc("t6b", 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all("t6c");
        chk("t6.wb_we", bus.wb_reg_write, 1'b0);
        chk("t6.fa_sel", bus.fwd_a_sel, 2'b00);

        // stall + flush: MEM becomes a bubble, WB holds
        cyc("t6d", 5'd12, 1'b1, 1'b0, 32'hC0DE, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        cyc("t6e", 5'd13, 1'b1, 1'b0, 32'hBEEF, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        saved_dest = bus.wb_reg_dest;
        saved_we   = bus.wb_reg_write;
        saved_data = bus.wb_write_data;
        cyc("t6f", 5'd14, 1'b1, 1'b0, 32'h1111, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1);
        drive(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all("t6g");
        chk("t6.sf_mem_dest", bus.mem_reg_dest,   5'd0);
        chk("t6.sf_mem_we",   bus.mem_reg_write,  1'b0);
        chk("t6.sf_mem_alu",  bus.mem_alu_result, 32'h0);
        chk("t6.sf_wb_dest",  bus.wb_reg_dest,    saved_dest);
        chk("t6.sf_wb_we",    bus.wb_reg_write,   saved_we);
        chk("t6.sf_wb_data",  bus.wb_write_data,  saved_data);
        chk("t6.sf_wb_12",    bus.wb_reg_dest,    5'd12);

        // JAL to $31 reaches write-back two cycles later
        cyc("t6h", 5'd31, 1'b1, 1'b0, 32'h0040_0008, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        cyc("t6i", 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 32'h0, 5'd31, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all("t6j");
        chk("t6.jal_dest", bus.wb_reg_dest,   5'd31);
        chk("t6.jal_we",   bus.wb_reg_write,  1'b1);
        chk("t6.jal_data", bus.wb_write_data, 32'h0040_0008);
        tick();

        // Randomized stream with occasional mid-stream asynchronous reset
        for (int n = 0; n < 400; n++) begin
            cyc("rnd", 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 3) == 0), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            if (n == 150 || n == 300) begin
                #2;
                reset_n = 1'b0;
                #1;
                check_zero("arst");
                pipe_m[0] = empty_rec();
                pipe_m[1] = empty_rec();
                @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
